// File: rtl/ddr_definitions.sv
// Shared game definitions for the dance-arrow pipeline: game states, arrow codes
// and the arrow-to-button mask decode used by the judge and the display driver.
package ddr_definitions;

  localparam int ARROW_CODE_W = 5;

  localparam logic [1:0] STATE_GAME  = 2'd1;
  localparam logic [1:0] STATE_PAUSE = 2'd2;

  localparam logic [ARROW_CODE_W-1:0] ARROW_UP         = 5'd10;
  localparam logic [ARROW_CODE_W-1:0] ARROW_DOWN       = 5'd11;
  localparam logic [ARROW_CODE_W-1:0] ARROW_LEFT       = 5'd12;
  localparam logic [ARROW_CODE_W-1:0] ARROW_RIGHT      = 5'd13;
  localparam logic [ARROW_CODE_W-1:0] ARROW_UP_LEFT    = 5'd14;
  localparam logic [ARROW_CODE_W-1:0] ARROW_UP_RIGHT   = 5'd15;
  localparam logic [ARROW_CODE_W-1:0] ARROW_DOWN_LEFT  = 5'd16;
  localparam logic [ARROW_CODE_W-1:0] ARROW_DOWN_RIGHT = 5'd17;
  localparam logic [ARROW_CODE_W-1:0] ARROW_UP_DOWN    = 5'd18;
  localparam logic [ARROW_CODE_W-1:0] ARROW_LEFT_RIGHT = 5'd19;
  localparam logic [ARROW_CODE_W-1:0] ARROW_NONE       = 5'd20;
  localparam logic [ARROW_CODE_W-1:0] ARROW_END        = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } judge_state_e;

  // Button order is {up, down, left, right}; NONE and digit codes need no press.
  function automatic logic [3:0] arrow_mask(input logic [ARROW_CODE_W-1:0] code);
    case (code)
      ARROW_UP:         return 4'b1000;
      ARROW_DOWN:       return 4'b0100;
      ARROW_LEFT:       return 4'b0010;
      ARROW_RIGHT:      return 4'b0001;
      ARROW_UP_LEFT:    return 4'b1010;
      ARROW_UP_RIGHT:   return 4'b1001;
      ARROW_DOWN_LEFT:  return 4'b0110;
      ARROW_DOWN_RIGHT: return 4'b0101;
      ARROW_UP_DOWN:    return 4'b1100;
      ARROW_LEFT_RIGHT: return 4'b0011;
      default:          return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/arrow_judge_if.sv
// Chart ROM bus: the judge drives the address, the synchronous ROM returns the
// arrow code one clock later.
interface arrow_judge_if #(
  parameter int ADDR_W  = 8,
  parameter int ARROW_W = 5
);
  logic [ADDR_W-1:0]  chart_addr;
  logic [ARROW_W-1:0] chart_data;

  modport master (output chart_addr, input chart_data);
  modport slave  (input chart_addr, output chart_data);
endinterface

// File: rtl/sync_rise_detect.sv
// Three-flop synchroniser for an asynchronous level, with a one-clock pulse on
// each rising edge of the synchronised signal.
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o
);
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], din_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/arrow_judge.sv
// Arrow judge: fills a 4-slot window from the chart ROM, scrolls it on every
// metronome beat and scores presses against slot3. Build option: COMBO_BONUS_EN.
module arrow_judge
  import ddr_definitions::*;
#(
  parameter int ARROW_W = 5,
  parameter int CNT_W   = 14,
  parameter int CNT_MAX = 9999,
  parameter int ADDR_W  = 8,
  parameter int STATE_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 metronome_clk,
  input  logic [STATE_W-1:0]   state,
  input  logic [3:0]           btn,
  input  logic                 restart,
  arrow_judge_if.master        chart,
  output logic [4*ARROW_W-1:0] cur_arrows,
  output logic [CNT_W-1:0]     score,
  output logic [CNT_W-1:0]     combo_count,
  output logic                 combo_enable,
  output logic                 hit,
  output logic                 miss,
  output logic                 song_done
);

  localparam logic [ARROW_W-1:0] NONE_C    = ARROW_W'(ARROW_NONE);
  localparam logic [ARROW_W-1:0] END_C     = ARROW_W'(ARROW_END);
  localparam logic [ADDR_W-1:0]  ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [2:0]         FILL_LAST = 3'd5;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum > (CNT_W+1)'(CNT_MAX)) return CNT_W'(CNT_MAX);
    return sum[CNT_W-1:0];
  endfunction

  logic       met_rise;
  logic [3:0] btn_rise;

  sync_rise_detect u_met_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (metronome_clk),
    .rise_o (met_rise)
  );

  for (genvar i = 0; i < 4; i++) begin : g_btn_sync
    sync_rise_detect u_btn_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (btn[i]),
      .rise_o (btn_rise[i])
    );
  end

  judge_state_e                fsm_q, fsm_d;
  logic [2:0]                  fill_q, fill_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [3:0][ARROW_W-1:0]     slots_q, slots_d;
  logic [ARROW_W-1:0]          next_q, next_d;
  logic                        end_seen_q, end_seen_d;
  logic [1:0]                  fetch_q, fetch_d;
  logic [3:0]                  press_q, press_d;
  logic [CNT_W-1:0]            score_q, score_d;
  logic [CNT_W-1:0]            combo_q, combo_d;
  logic                        combo_en_q, combo_en_d;
  logic                        hit_q, hit_d;
  logic                        miss_q, miss_d;

  logic                        game_on;
  logic                        word_end;
  logic [ARROW_W-1:0]          word;
  logic [3:0]                  req_mask;
  logic [1:0]                  score_inc;

  assign game_on = (state == STATE_W'(STATE_GAME));

  always_comb begin
    fsm_d      = fsm_q;
    fill_d     = fill_q;
    addr_d     = addr_q;
    slots_d    = slots_q;
    next_d     = next_q;
    end_seen_d = end_seen_q;
    fetch_d    = {fetch_q[0], 1'b0};
    press_d    = '0;
    score_d    = score_q;
    combo_d    = combo_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    word_end = (chart.chart_data == END_C) || end_seen_q;
    word     = word_end ? NONE_C : chart.chart_data;
    req_mask = arrow_mask(ARROW_CODE_W'(slots_q[3]));
`ifdef COMBO_BONUS_EN
    score_inc = (combo_q >= CNT_W'(10)) ? 2'd2 : 2'd1;
`else
    score_inc = 2'd1;
`endif

    case (fsm_q)
      S_IDLE: begin
        score_d = '0;
        combo_d = '0;
        // Words for addresses 0..3 arrive on fill steps 1..4; step 5 brings the prefetch.
        if (fill_q != 3'd0) begin
          end_seen_d = word_end;
          if (fill_q == FILL_LAST) begin
            next_d = word;
            fsm_d  = S_RUN;
          end else begin
            slots_d = {slots_q[2:0], word};
          end
        end
        if (fill_q != FILL_LAST) fill_d = fill_q + 3'd1;
        if (fill_q < 3'd4 && !end_seen_d) addr_d = addr_q + ADDR_W'(1);
      end

      S_RUN: begin
        if (fetch_q[1]) begin
          if (word_end || addr_q == ADDR_MAX) begin
            next_d     = NONE_C;
            end_seen_d = 1'b1;
          end else begin
            next_d = chart.chart_data;
          end
        end
        if (game_on) begin
          if (met_rise) begin
            if (slots_q[3] != NONE_C) begin
              if (press_q == req_mask) hit_d  = 1'b1;
              else                     miss_d = 1'b1;
            end else if (press_q != 4'b0000) begin
              miss_d = 1'b1;
            end
            if (hit_d) begin
              score_d = sat_add(score_q, score_inc);
              combo_d = sat_add(combo_q, 2'd1);
            end
            if (miss_d) combo_d = '0;
            slots_d = {slots_q[2:0], next_q};
            if (!end_seen_q) begin
              addr_d     = addr_q + ADDR_W'(1);
              fetch_d[0] = 1'b1;
            end
            // An edge landing on the beat itself belongs to the following beat.
            press_d = btn_rise;
          end else begin
            press_d = press_q | btn_rise;
          end
          if (end_seen_q && slots_q == {4{NONE_C}} && next_q == NONE_C) fsm_d = S_DONE;
        end
      end

      S_DONE: ;

      default: fsm_d = S_IDLE;
    endcase

    if (restart) begin
      fsm_d      = S_IDLE;
      fill_d     = '0;
      addr_d     = '0;
      slots_d    = {4{NONE_C}};
      next_d     = NONE_C;
      end_seen_d = 1'b0;
      fetch_d    = '0;
      press_d    = '0;
      score_d    = '0;
      combo_d    = '0;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
    end

    combo_en_d = (combo_d >= CNT_W'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= S_IDLE;
      fill_q     <= '0;
      addr_q     <= '0;
      slots_q    <= {4{NONE_C}};
      next_q     <= NONE_C;
      end_seen_q <= 1'b0;
      fetch_q    <= '0;
      press_q    <= '0;
      score_q    <= '0;
      combo_q    <= '0;
      combo_en_q <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      fill_q     <= fill_d;
      addr_q     <= addr_d;
      slots_q    <= slots_d;
      next_q     <= next_d;
      end_seen_q <= end_seen_d;
      fetch_q    <= fetch_d;
      press_q    <= press_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      combo_en_q <= combo_en_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign chart.chart_addr = addr_q;
  assign cur_arrows       = slots_q;
  assign score            = score_q;
  assign combo_count      = combo_q;
  assign combo_enable     = combo_en_q;
  assign hit              = hit_q;
  assign miss             = miss_q;
  assign song_done        = (fsm_q == S_DONE);

endmodule

// File: tb/tb_arrow_judge.sv
// Directed bench for arrow_judge with a behavioural synchronous chart ROM.
// The score ceiling is lowered to 15 so a 20-arrow chart reaches saturation.
module tb_arrow_judge;
  import ddr_definitions::*;

  localparam int AW   = 5;
  localparam int CW   = 14;
  localparam int CMAX = 15;
  localparam int ADW  = 8;
  localparam int SW   = 2;
  localparam int N    = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            metronome_clk = 1'b0;
  logic            restart = 1'b0;
  logic [SW-1:0]   state = STATE_GAME;
  logic [3:0]      btn = 4'b0000;
  logic [4*AW-1:0] cur_arrows;
  logic [CW-1:0]   score;
  logic [CW-1:0]   combo_count;
  logic            combo_enable;
  logic            hit;
  logic            miss;
  logic            song_done;

  logic [AW-1:0]   rom [0:255];
  logic            saw_hit;
  logic            saw_miss;
  int              checks = 0;
  int              errors = 0;

  arrow_judge_if #(.ADDR_W(ADW), .ARROW_W(AW)) chart_bus ();

  arrow_judge #(
    .ARROW_W (AW),
    .CNT_W   (CW),
    .CNT_MAX (CMAX),
    .ADDR_W  (ADW),
    .STATE_W (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .metronome_clk (metronome_clk),
    .state         (state),
    .btn           (btn),
    .restart       (restart),
    .chart         (chart_bus.master),
    .cur_arrows    (cur_arrows),
    .score         (score),
    .combo_count   (combo_count),
    .combo_enable  (combo_enable),
    .hit           (hit),
    .miss          (miss),
    .song_done     (song_done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) chart_bus.chart_data <= rom[chart_bus.chart_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, expected, expected);
    end
  endtask

  function automatic logic [31:0] arw(input int a3, input int a2, input int a1, input int a0);
    return {12'd0, 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic press(input logic [3:0] m);
    @(posedge clk); #1 btn = m;
    repeat (3) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (2) @(posedge clk);
  endtask

  // One metronome period; judgement pulses are collected over a fixed window.
  task automatic beat();
    saw_hit  = 1'b0;
    saw_miss = 1'b0;
    @(posedge clk); #1 metronome_clk = 1'b1;
    repeat (8) begin
      @(negedge clk);
      saw_hit  = saw_hit | hit;
      saw_miss = saw_miss | miss;
    end
    metronome_clk = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_hit  = saw_hit | hit;
      saw_miss = saw_miss | miss;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = ARROW_END;
    rom[0] = ARROW_UP;
    rom[1] = ARROW_DOWN;
    rom[2] = ARROW_NONE;
    rom[3] = ARROW_RIGHT;
    rom[4] = ARROW_END;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arrows", 32'(cur_arrows), arw(N, N, N, N));
    check("rst_addr", 32'(chart_bus.chart_addr), 0);
    check("rst_score", 32'(score), 0);
    check("rst_combo", 32'(combo_count), 0);
    check("rst_pulses", 32'({hit, miss, song_done, combo_enable}), 0);

    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("fill_arrows", 32'(cur_arrows), arw(10, 11, 20, 13));
    check("fill_addr", 32'(chart_bus.chart_addr), 4);
    check("fill_done", 32'(song_done), 0);

    press(4'b1000);
    beat();
    check("up_hit", 32'({saw_hit, saw_miss}), 32'b10);
    check("up_score", 32'(score), 1);
    check("up_combo", 32'(combo_count), 1);
    check("up_combo_en", 32'(combo_enable), 0);
    check("up_shift", 32'(cur_arrows), arw(11, 20, 13, N));

    press(4'b0010);
    beat();
    check("down_miss", 32'({saw_hit, saw_miss}), 32'b01);
    check("down_score", 32'(score), 1);
    check("down_combo", 32'(combo_count), 0);
    check("down_shift", 32'(cur_arrows), arw(20, 13, N, N));

    beat();
    check("none_quiet", 32'({saw_hit, saw_miss}), 32'b00);
    check("none_shift", 32'(cur_arrows), arw(13, N, N, N));

    state = STATE_PAUSE;
    press(4'b0001);
    beat();
    check("pause_quiet", 32'({saw_hit, saw_miss}), 32'b00);
    check("pause_arrows", 32'(cur_arrows), arw(13, N, N, N));
    check("pause_score", 32'(score), 1);

    state = STATE_GAME;
    press(4'b0001);
    beat();
    check("resume_hit", 32'({saw_hit, saw_miss}), 32'b10);
    check("resume_score", 32'(score), 2);
    check("resume_arrows", 32'(cur_arrows), arw(N, N, N, N));
    check("song_done", 32'(song_done), 1);

    press(4'b1000);
    beat();
    check("done_quiet", 32'({saw_hit, saw_miss}), 32'b00);
    check("done_score", 32'(score), 2);

    rom[0] = ARROW_NONE;
    for (int i = 1; i <= 22; i++) rom[i] = ARROW_UP;
    rom[23] = ARROW_END;
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    @(negedge clk);
    check("rs_score", 32'(score), 0);
    check("rs_addr", 32'(chart_bus.chart_addr), 0);
    check("rs_done", 32'(song_done), 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("b_fill", 32'(cur_arrows), arw(20, 10, 10, 10));

    press(4'b0001);
    beat();
    check("none_press_miss", 32'({saw_hit, saw_miss}), 32'b01);
    check("none_press_combo", 32'(combo_count), 0);

    for (int n = 1; n <= 20; n++) begin
      press(4'b1000);
      beat();
      check("run_hit", 32'({saw_hit, saw_miss}), 32'b10);
      if (n == 2) check("combo_en_on", 32'(combo_enable), 1);
      if (n == 10) check("score_10", 32'(score), 10);
`ifdef COMBO_BONUS_EN
      if (n == 11) check("score_11_bonus", 32'(score), 12);
`else
      if (n == 11) check("score_11", 32'(score), 11);
`endif
    end
    check("score_sat", 32'(score), CMAX);
    check("combo_sat", 32'(combo_count), CMAX);
    check("sat_arrows", 32'(cur_arrows), arw(10, 10, N, N));

    press(4'b1000);
    @(posedge clk); #1 metronome_clk = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    @(negedge clk);
    check("rt_pulses", 32'({hit, miss}), 0);
    check("rt_score", 32'(score), 0);
    check("rt_combo", 32'(combo_count), 0);
    check("rt_addr", 32'(chart_bus.chart_addr), 0);
    metronome_clk = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("rt_refill", 32'(cur_arrows), arw(20, 10, 10, 10));
    check("rt_score_hold", 32'(score), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
